mmu_port_arbiter: RTL and testbench

Shares the single logic-address port of the MMU between the instruction-fetch and data load/store requesters. Arbitrates round-robin, tracks outstanding reads in an in-order tag queue, and routes returned data and page faults back to the issuing requester. Also sequences TLB flush: it drains all outstanding traffic before pulsing the MMU flush. Sits between the core's fetch/LSU front ends and the MMU's `iLOGIC_*` / memory-return ports.

---
 rtl/mmu_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mmu_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_port_arbiter.sv
// Round-robin arbiter sharing the MMU logic-address port between fetch and load/store,
// with an in-order read tag queue for response routing and a drain-then-flush TLB sequencer.
module mmu_port_arbiter #(
   parameter int P_DEPTH   = 4,
   parameter int P_DEPTH_N = 2
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic [1:0]  iMODE,
   input  logic [31:0] iPDT,
   input  logic        iFLUSH_REQ,
   output logic        oFLUSH_ACK,
   input  logic        iFETCH_REQ,
   input  logic [1:0]  iFETCH_ORDER,
   input  logic [3:0]  iFETCH_MASK,
   input  logic        iFETCH_RW,
   input  logic [31:0] iFETCH_ADDR,
   input  logic [31:0] iFETCH_DATA,
   input  logic        iFETCH_DATA_STORE_ACK,
   output logic        oFETCH_LOCK,
   input  logic        iLDST_REQ,
   input  logic [1:0]  iLDST_ORDER,
   input  logic [3:0]  iLDST_MASK,
   input  logic        iLDST_RW,
   input  logic [31:0] iLDST_ADDR,
   input  logic [31:0] iLDST_DATA,
   input  logic        iLDST_DATA_STORE_ACK,
   output logic        oLDST_LOCK,
   output logic        oMMU_REQ,
   output logic [1:0]  oMMU_ORDER,
   output logic [3:0]  oMMU_MASK,
   output logic        oMMU_RW,
   output logic [31:0] oMMU_ADDR,
   output logic [31:0] oMMU_DATA,
   output logic        oMMU_DATA_STORE_ACK,
   output logic [1:0]  oMMU_MODE,
   output logic [31:0] oMMU_PDT,
   input  logic        iMMU_LOCK,
   output logic        oMMU_TLB_FLASH,
   input  logic        iRESP_VALID,
   input  logic [63:0] iRESP_DATA,
   output logic        oRESP_LOCK,
   input  logic        iPAGEFAULT,
   output logic        oFETCH_VALID,
   output logic        oLDST_VALID,
   output logic [63:0] oFETCH_DATA,
   output logic [63:0] oLDST_DATA,
   output logic        oFETCH_PAGEFAULT,
   output logic        oLDST_PAGEFAULT,
   output logic        oRESP_ERROR
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLASH} state_t;

   localparam logic [P_DEPTH_N:0] COUNT_FULL = (P_DEPTH_N + 1)'(P_DEPTH);

   state_t               state_q, state_d;
   logic [P_DEPTH_N:0]   count_q, count_d;
   logic [P_DEPTH_N-1:0] wr_ptr_q, rd_ptr_q;
   logic                 last_grant_q;
   logic                 resp_error_q;
   logic                 tag_q [P_DEPTH];

   logic eligible, any_req, grant_ldst, accept, push, pop, nonempty, head, resp_any;

   // A flush request blocks grants immediately, even in its first RUN cycle.
   assign eligible   = (state_q == ST_RUN) && !iFLUSH_REQ && (count_q != COUNT_FULL) && !iMMU_LOCK;
   assign any_req    = iFETCH_REQ || iLDST_REQ;
   assign grant_ldst = iLDST_REQ && (!iFETCH_REQ || !last_grant_q);

   always_comb begin
      oMMU_REQ            = eligible && any_req;
      oMMU_ORDER          = grant_ldst ? iLDST_ORDER : iFETCH_ORDER;
      oMMU_MASK           = grant_ldst ? iLDST_MASK : iFETCH_MASK;
      oMMU_RW             = grant_ldst ? iLDST_RW : iFETCH_RW;
      oMMU_ADDR           = grant_ldst ? iLDST_ADDR : iFETCH_ADDR;
      oMMU_DATA           = grant_ldst ? iLDST_DATA : iFETCH_DATA;
      oMMU_DATA_STORE_ACK = grant_ldst ? iLDST_DATA_STORE_ACK : iFETCH_DATA_STORE_ACK;
      oFETCH_LOCK         = !eligible || (any_req && grant_ldst);
      oLDST_LOCK          = !eligible || (any_req && !grant_ldst);
   end

   assign oMMU_MODE      = iMODE;
   assign oMMU_PDT       = iPDT;
   assign oMMU_TLB_FLASH = (state_q == ST_FLASH);
   assign oFLUSH_ACK     = (state_q == ST_FLASH);
   assign oRESP_LOCK     = 1'b0;

   assign accept   = oMMU_REQ && !iMMU_LOCK;
   assign push     = accept && !oMMU_RW;
   assign nonempty = (count_q != '0);
   assign resp_any = iRESP_VALID || iPAGEFAULT;
   assign pop      = resp_any && nonempty;
   assign head     = tag_q[rd_ptr_q];

   // A fault outranks a simultaneous data return for the same head entry.
   assign oFETCH_VALID     = iRESP_VALID && !iPAGEFAULT && nonempty && !head;
   assign oLDST_VALID      = iRESP_VALID && !iPAGEFAULT && nonempty && head;
   assign oFETCH_PAGEFAULT = iPAGEFAULT && nonempty && !head;
   assign oLDST_PAGEFAULT  = iPAGEFAULT && nonempty && head;
   assign oFETCH_DATA      = iRESP_DATA;
   assign oLDST_DATA       = iRESP_DATA;
   assign oRESP_ERROR      = resp_error_q;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (iFLUSH_REQ) state_d = ST_DRAIN;
         ST_DRAIN: if (count_q == '0) state_d = ST_FLASH;
         ST_FLASH: state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q      <= ST_RUN;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         last_grant_q <= 1'b1;
         resp_error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (accept) last_grant_q <= grant_ldst;
         if (resp_any && !nonempty) resp_error_q <= 1'b1;
      end
   end

   // Tag storage is never reset: entries are only read while counted as valid.
   always_ff @(posedge iCLOCK) begin
      if (push) tag_q[wr_ptr_q] <= grant_ldst;
   end

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Directed self-checking bench for mmu_port_arbiter: arbitration, tag queue routing,
// page faults, flush sequencing and orphan-response error.
module tb_mmu_port_arbiter;

   logic        iCLOCK = 1'b0;
   logic        inRESET;
   logic [1:0]  iMODE;
   logic [31:0] iPDT;
   logic        iFLUSH_REQ, oFLUSH_ACK;
   logic        iFETCH_REQ, iFETCH_RW, iFETCH_DATA_STORE_ACK, oFETCH_LOCK;
   logic [1:0]  iFETCH_ORDER;
   logic [3:0]  iFETCH_MASK;
   logic [31:0] iFETCH_ADDR, iFETCH_DATA;
   logic        iLDST_REQ, iLDST_RW, iLDST_DATA_STORE_ACK, oLDST_LOCK;
   logic [1:0]  iLDST_ORDER;
   logic [3:0]  iLDST_MASK;
   logic [31:0] iLDST_ADDR, iLDST_DATA;
   logic        oMMU_REQ, oMMU_RW, oMMU_DATA_STORE_ACK;
   logic [1:0]  oMMU_ORDER, oMMU_MODE;
   logic [3:0]  oMMU_MASK;
   logic [31:0] oMMU_ADDR, oMMU_DATA, oMMU_PDT;
   logic        iMMU_LOCK, oMMU_TLB_FLASH;
   logic        iRESP_VALID, oRESP_LOCK, iPAGEFAULT;
   logic [63:0] iRESP_DATA, oFETCH_DATA, oLDST_DATA;
   logic        oFETCH_VALID, oLDST_VALID, oFETCH_PAGEFAULT, oLDST_PAGEFAULT, oRESP_ERROR;

   int errors = 0;
   int checks = 0;

   always #5 iCLOCK = ~iCLOCK;

   mmu_port_arbiter #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
      .iCLOCK(iCLOCK), .inRESET(inRESET), .iMODE(iMODE), .iPDT(iPDT),
      .iFLUSH_REQ(iFLUSH_REQ), .oFLUSH_ACK(oFLUSH_ACK),
      .iFETCH_REQ(iFETCH_REQ), .iFETCH_ORDER(iFETCH_ORDER), .iFETCH_MASK(iFETCH_MASK),
      .iFETCH_RW(iFETCH_RW), .iFETCH_ADDR(iFETCH_ADDR), .iFETCH_DATA(iFETCH_DATA),
      .iFETCH_DATA_STORE_ACK(iFETCH_DATA_STORE_ACK), .oFETCH_LOCK(oFETCH_LOCK),
      .iLDST_REQ(iLDST_REQ), .iLDST_ORDER(iLDST_ORDER), .iLDST_MASK(iLDST_MASK),
      .iLDST_RW(iLDST_RW), .iLDST_ADDR(iLDST_ADDR), .iLDST_DATA(iLDST_DATA),
      .iLDST_DATA_STORE_ACK(iLDST_DATA_STORE_ACK), .oLDST_LOCK(oLDST_LOCK),
      .oMMU_REQ(oMMU_REQ), .oMMU_ORDER(oMMU_ORDER), .oMMU_MASK(oMMU_MASK), .oMMU_RW(oMMU_RW),
      .oMMU_ADDR(oMMU_ADDR), .oMMU_DATA(oMMU_DATA), .oMMU_DATA_STORE_ACK(oMMU_DATA_STORE_ACK),
      .oMMU_MODE(oMMU_MODE), .oMMU_PDT(oMMU_PDT), .iMMU_LOCK(iMMU_LOCK),
      .oMMU_TLB_FLASH(oMMU_TLB_FLASH), .iRESP_VALID(iRESP_VALID), .iRESP_DATA(iRESP_DATA),
      .oRESP_LOCK(oRESP_LOCK), .iPAGEFAULT(iPAGEFAULT),
      .oFETCH_VALID(oFETCH_VALID), .oLDST_VALID(oLDST_VALID),
      .oFETCH_DATA(oFETCH_DATA), .oLDST_DATA(oLDST_DATA),
      .oFETCH_PAGEFAULT(oFETCH_PAGEFAULT), .oLDST_PAGEFAULT(oLDST_PAGEFAULT),
      .oRESP_ERROR(oRESP_ERROR)
   );

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge iCLOCK);
      #1;
   endtask

   task automatic init_inputs();
      iMODE = 2'd0; iPDT = 32'd0; iFLUSH_REQ = 1'b0; iMMU_LOCK = 1'b0;
      iFETCH_REQ = 1'b0; iFETCH_ORDER = 2'd0; iFETCH_MASK = 4'hF; iFETCH_RW = 1'b0;
      iFETCH_ADDR = 32'd0; iFETCH_DATA = 32'd0; iFETCH_DATA_STORE_ACK = 1'b0;
      iLDST_REQ = 1'b0; iLDST_ORDER = 2'd0; iLDST_MASK = 4'hF; iLDST_RW = 1'b0;
      iLDST_ADDR = 32'd0; iLDST_DATA = 32'd0; iLDST_DATA_STORE_ACK = 1'b0;
      iRESP_VALID = 1'b0; iRESP_DATA = 64'd0; iPAGEFAULT = 1'b0;
   endtask

   task automatic apply_reset();
      init_inputs();
      inRESET = 1'b0;
      repeat (2) @(posedge iCLOCK);
      #1;
      inRESET = 1'b1;
   endtask

   task automatic test_reset();
      init_inputs();
      inRESET = 1'b0;
      #3;
      checks++; if (oMMU_REQ !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", oMMU_REQ); end
      checks++; if ({oFETCH_LOCK, oLDST_LOCK} !== 2'b00) begin errors++; $display("FAIL reset_locks: got %b want 00", {oFETCH_LOCK, oLDST_LOCK}); end
      checks++; if ({oFETCH_VALID, oLDST_VALID, oMMU_TLB_FLASH, oFLUSH_ACK, oRESP_ERROR, oRESP_LOCK} !== 6'b0)
         begin errors++; $display("FAIL reset_flags: got %b want 000000", {oFETCH_VALID, oLDST_VALID, oMMU_TLB_FLASH, oFLUSH_ACK, oRESP_ERROR, oRESP_LOCK}); end
      apply_reset();
      #1;
      checks++; if ({oMMU_REQ, oFETCH_LOCK, oLDST_LOCK, oRESP_ERROR} !== 4'b0) begin errors++; $display("FAIL reset_after: got %b want 0000", {oMMU_REQ, oFETCH_LOCK, oLDST_LOCK, oRESP_ERROR}); end
      $display("test_reset done");
   endtask

   task automatic test_single_fetch();
      apply_reset();
      iFETCH_REQ = 1'b1; iFETCH_RW = 1'b0; iFETCH_ADDR = 32'h0000_1000;
      #1;
      checks++; if (oMMU_REQ !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", oMMU_REQ); end
      checks++; if (oMMU_ADDR !== 32'h0000_1000) begin errors++; $display("FAIL single_addr: got %h want 00001000", oMMU_ADDR); end
      checks++; if (oFETCH_LOCK !== 1'b0) begin errors++; $display("FAIL single_lock: got %b want 0", oFETCH_LOCK); end
      tick();
      iFETCH_REQ = 1'b0;
      tick();
      iRESP_VALID = 1'b1; iRESP_DATA = 64'h1122334455667788;
      #1;
      checks++; if ({oFETCH_VALID, oLDST_VALID} !== 2'b10) begin errors++; $display("FAIL single_valid: got %b want 10", {oFETCH_VALID, oLDST_VALID}); end
      checks++; if (oFETCH_DATA !== 64'h1122334455667788) begin errors++; $display("FAIL single_data: got %h want 1122334455667788", oFETCH_DATA); end
      tick();
      iRESP_VALID = 1'b0;
      $display("test_single_fetch done");
   endtask

   task automatic test_contention();
      logic exp_ldst;
      apply_reset();
      iFETCH_REQ = 1'b1; iFETCH_ADDR = 32'h100;
      iLDST_REQ = 1'b1; iLDST_ADDR = 32'h200;
      for (int i = 0; i < 4; i++) begin
         exp_ldst = (i % 2) == 1;
         #1;
         checks++; if (oMMU_REQ !== 1'b1 || oMMU_ADDR !== (exp_ldst ? 32'h200 : 32'h100))
            begin errors++; $display("FAIL contend_grant%0d: got req=%b addr=%h want req=1 addr=%h", i, oMMU_REQ, oMMU_ADDR, exp_ldst ? 32'h200 : 32'h100); end
         checks++; if ({oFETCH_LOCK, oLDST_LOCK} !== {exp_ldst, !exp_ldst})
            begin errors++; $display("FAIL contend_locks%0d: got %b want %b", i, {oFETCH_LOCK, oLDST_LOCK}, {exp_ldst, !exp_ldst}); end
         tick();
      end
      #1;
      checks++; if ({oMMU_REQ, oFETCH_LOCK, oLDST_LOCK} !== 3'b011) begin errors++; $display("FAIL full_block: got %b want 011", {oMMU_REQ, oFETCH_LOCK, oLDST_LOCK}); end
      iRESP_VALID = 1'b1; iRESP_DATA = 64'hA0;
      #1;
      checks++; if ({oMMU_REQ, oFETCH_VALID, oLDST_VALID} !== 3'b010) begin errors++; $display("FAIL full_pop_nogrant: got %b want 010", {oMMU_REQ, oFETCH_VALID, oLDST_VALID}); end
      tick();
      iRESP_VALID = 1'b0;
      #1;
      checks++; if (oMMU_REQ !== 1'b1 || oMMU_ADDR !== 32'h100) begin errors++; $display("FAIL full_regrant: got req=%b addr=%h want req=1 addr=00000100", oMMU_REQ, oMMU_ADDR); end
      tick();
      iFETCH_REQ = 1'b0; iLDST_REQ = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_ldst = (i % 2) == 0;
         iRESP_VALID = 1'b1; iRESP_DATA = 64'(i);
         #1;
         checks++; if ({oFETCH_VALID, oLDST_VALID} !== {!exp_ldst, exp_ldst})
            begin errors++; $display("FAIL contend_route%0d: got %b want %b", i, {oFETCH_VALID, oLDST_VALID}, {!exp_ldst, exp_ldst}); end
         tick();
      end
      iRESP_VALID = 1'b0;
      $display("test_contention done");
   endtask

   task automatic test_pagefault();
      iLDST_REQ = 1'b1; iLDST_RW = 1'b0; iLDST_ADDR = 32'h300;
      #1;
      checks++; if (oMMU_REQ !== 1'b1 || oLDST_LOCK !== 1'b0 || oMMU_ADDR !== 32'h300) begin errors++; $display("FAIL pf_ldst_grant: got req=%b lock=%b addr=%h want 1 0 00000300", oMMU_REQ, oLDST_LOCK, oMMU_ADDR); end
      tick();
      iLDST_REQ = 1'b0; iFETCH_REQ = 1'b1; iFETCH_ADDR = 32'h400;
      tick();
      iFETCH_REQ = 1'b0; iPAGEFAULT = 1'b1;
      #1;
      checks++; if ({oLDST_PAGEFAULT, oFETCH_PAGEFAULT, oLDST_VALID} !== 3'b100) begin errors++; $display("FAIL pf_route: got %b want 100", {oLDST_PAGEFAULT, oFETCH_PAGEFAULT, oLDST_VALID}); end
      tick();
      iPAGEFAULT = 1'b0; iRESP_VALID = 1'b1;
      #1;
      checks++; if ({oFETCH_VALID, oLDST_VALID} !== 2'b10) begin errors++; $display("FAIL pf_next_valid: got %b want 10", {oFETCH_VALID, oLDST_VALID}); end
      tick();
      iRESP_VALID = 1'b0; iFETCH_REQ = 1'b1;
      tick();
      iFETCH_REQ = 1'b0; iRESP_VALID = 1'b1; iPAGEFAULT = 1'b1;
      #1;
      checks++; if ({oFETCH_PAGEFAULT, oFETCH_VALID, oLDST_PAGEFAULT} !== 3'b100) begin errors++; $display("FAIL pf_priority: got %b want 100", {oFETCH_PAGEFAULT, oFETCH_VALID, oLDST_PAGEFAULT}); end
      tick();
      iRESP_VALID = 1'b0; iPAGEFAULT = 1'b0;
      $display("test_pagefault done");
   endtask

   task automatic test_write();
      iLDST_REQ = 1'b1; iLDST_RW = 1'b1; iLDST_ADDR = 32'h600; iLDST_DATA = 32'hDEAD_BEEF;
      iLDST_MASK = 4'hC; iLDST_ORDER = 2'd2; iMODE = 2'd2; iPDT = 32'h1234_5000;
      #1;
      checks++; if ({oMMU_REQ, oMMU_RW, oMMU_MASK, oMMU_ORDER} !== {1'b1, 1'b1, 4'hC, 2'd2})
         begin errors++; $display("FAIL write_ctrl: got req=%b rw=%b mask=%h order=%0d want 1 1 c 2", oMMU_REQ, oMMU_RW, oMMU_MASK, oMMU_ORDER); end
      checks++; if (oMMU_DATA !== 32'hDEAD_BEEF || oMMU_MODE !== 2'd2 || oMMU_PDT !== 32'h1234_5000)
         begin errors++; $display("FAIL write_pass: got data=%h mode=%0d pdt=%h want deadbeef 2 12345000", oMMU_DATA, oMMU_MODE, oMMU_PDT); end
      tick();
      iLDST_REQ = 1'b0; iLDST_RW = 1'b0; iLDST_MASK = 4'hF; iLDST_ORDER = 2'd0;
      $display("test_write done");
   endtask

   task automatic test_flush_idle();
      iFETCH_REQ = 1'b1; iFETCH_ADDR = 32'h500; iFLUSH_REQ = 1'b1;
      #1;
      checks++; if ({oMMU_REQ, oFLUSH_ACK} !== 2'b00) begin errors++; $display("FAIL flush_n: got %b want 00", {oMMU_REQ, oFLUSH_ACK}); end
      tick(); #1;
      checks++; if ({oFLUSH_ACK, oFETCH_LOCK, oLDST_LOCK} !== 3'b011) begin errors++; $display("FAIL flush_n1: got %b want 011", {oFLUSH_ACK, oFETCH_LOCK, oLDST_LOCK}); end
      tick(); #1;
      checks++; if ({oFLUSH_ACK, oMMU_TLB_FLASH, oMMU_REQ} !== 3'b110) begin errors++; $display("FAIL flush_n2: got %b want 110", {oFLUSH_ACK, oMMU_TLB_FLASH, oMMU_REQ}); end
      tick();
      iFLUSH_REQ = 1'b0;
      #1;
      checks++; if ({oFLUSH_ACK, oMMU_TLB_FLASH, oMMU_REQ} !== 3'b001) begin errors++; $display("FAIL flush_n3: got %b want 001", {oFLUSH_ACK, oMMU_TLB_FLASH, oMMU_REQ}); end
      tick();
      iFETCH_REQ = 1'b0; iRESP_VALID = 1'b1;
      tick();
      iRESP_VALID = 1'b0;
      $display("test_flush_idle done");
   endtask

   task automatic test_flush_traffic();
      iFETCH_REQ = 1'b1; iFETCH_ADDR = 32'h700;
      repeat (3) tick();
      iFLUSH_REQ = 1'b1;
      #1;
      checks++; if (oMMU_REQ !== 1'b0) begin errors++; $display("FAIL flt_first: got %b want 0", oMMU_REQ); end
      tick();
      for (int i = 0; i < 3; i++) begin
         iRESP_VALID = 1'b1;
         #1;
         checks++; if ({oFETCH_VALID, oMMU_REQ, oFETCH_LOCK, oFLUSH_ACK} !== 4'b1010)
            begin errors++; $display("FAIL flt_drain%0d: got %b want 1010", i, {oFETCH_VALID, oMMU_REQ, oFETCH_LOCK, oFLUSH_ACK}); end
         tick();
      end
      iRESP_VALID = 1'b0;
      #1;
      checks++; if ({oFLUSH_ACK, oMMU_REQ} !== 2'b00) begin errors++; $display("FAIL flt_empty: got %b want 00", {oFLUSH_ACK, oMMU_REQ}); end
      tick(); #1;
      checks++; if ({oFLUSH_ACK, oMMU_TLB_FLASH, oMMU_REQ} !== 3'b110) begin errors++; $display("FAIL flt_pulse: got %b want 110", {oFLUSH_ACK, oMMU_TLB_FLASH, oMMU_REQ}); end
      tick();
      iFLUSH_REQ = 1'b0;
      #1;
      checks++; if ({oFLUSH_ACK, oMMU_REQ, oFETCH_LOCK} !== 3'b010) begin errors++; $display("FAIL flt_resume: got %b want 010", {oFLUSH_ACK, oMMU_REQ, oFETCH_LOCK}); end
      tick();
      iFETCH_REQ = 1'b0; iRESP_VALID = 1'b1;
      tick();
      iRESP_VALID = 1'b0;
      $display("test_flush_traffic done");
   endtask

   task automatic test_orphan();
      iRESP_VALID = 1'b1;
      #1;
      checks++; if ({oFETCH_VALID, oLDST_VALID, oRESP_ERROR} !== 3'b000) begin errors++; $display("FAIL orphan_novalid: got %b want 000", {oFETCH_VALID, oLDST_VALID, oRESP_ERROR}); end
      tick();
      iRESP_VALID = 1'b0;
      repeat (3) tick();
      checks++; if (oRESP_ERROR !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", oRESP_ERROR); end
      iFETCH_REQ = 1'b1;
      tick();
      iFETCH_REQ = 1'b0;
      inRESET = 1'b0;
      #1;
      checks++; if (oRESP_ERROR !== 1'b0) begin errors++; $display("FAIL orphan_reset: got %b want 0", oRESP_ERROR); end
      tick();
      inRESET = 1'b1;
      iRESP_VALID = 1'b1;
      #1;
      checks++; if ({oFETCH_VALID, oLDST_VALID} !== 2'b00) begin errors++; $display("FAIL midreset_valid: got %b want 00", {oFETCH_VALID, oLDST_VALID}); end
      tick();
      iRESP_VALID = 1'b0;
      #1;
      checks++; if (oRESP_ERROR !== 1'b1) begin errors++; $display("FAIL midreset_error: got %b want 1", oRESP_ERROR); end
      $display("test_orphan done");
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_contention();
      test_pagefault();
      test_write();
      test_flush_idle();
      test_flush_traffic();
      test_orphan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
